// File: rtl/fight_pkg.sv
// fight_pkg: shared box type, player/round state encodings, winner codes and saturating damage helper
package fight_pkg;
  typedef struct packed {
    logic [9:0] x1;
    logic [9:0] x2;
    logic [9:0] y1;
    logic [9:0] y2;
  } box_t;
  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_MOVEFORWARDS = 4'd1;
  localparam logic [3:0] S_MOVEBACKWARDS = 4'd2;
  localparam logic [3:0] S_B_ATTACK_START = 4'd3;
  localparam logic [3:0] S_B_ATTACK_END = 4'd4;
  localparam logic [3:0] S_B_ATTACK_PULL = 4'd5;
  localparam logic [3:0] DIR_ACTIVE = 4'd7;
  typedef enum logic [1:0] {R_FIGHT, R_KO, R_OVER} round_t;
  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W_LEFT = 2'b01;
  localparam logic [1:0] W_RIGHT = 2'b10;
  localparam logic [1:0] W_DRAW = 2'b11;
  function automatic logic [6:0] sub_sat(input logic [6:0] hp, input logic [6:0] d);
    return hp > d ? hp - d : 7'd0;
  endfunction
endpackage

// File: rtl/hit_resolver_if.sv
// hit_resolver_if: player state and hit/hurt boxes of both sides; master = players, slave = resolver
interface hit_resolver_if;
  import fight_pkg::*;
  logic [3:0] state_l;
  logic [3:0] state_r;
  box_t basic_l;
  box_t basic_r;
  box_t dir_l;
  box_t dir_r;
  box_t hurt_l;
  box_t hurt_r;
  modport master(output state_l, state_r, basic_l, basic_r, dir_l, dir_r, hurt_l, hurt_r);
  modport slave(input state_l, state_r, basic_l, basic_r, dir_l, dir_r, hurt_l, hurt_r);
endinterface

// File: rtl/box_overlap.sv
// box_overlap: normalizes two boxes per axis and reports inclusive overlap (a, b in; hit out)
module box_overlap
  import fight_pkg::*;
(
  input  box_t a,
  input  box_t b,
  output logic hit
);
  logic [9:0] ax_lo, ax_hi, ay_lo, ay_hi, bx_lo, bx_hi, by_lo, by_hi;
  assign ax_lo = a.x1 < a.x2 ? a.x1 : a.x2;
  assign ax_hi = a.x1 < a.x2 ? a.x2 : a.x1;
  assign ay_lo = a.y1 < a.y2 ? a.y1 : a.y2;
  assign ay_hi = a.y1 < a.y2 ? a.y2 : a.y1;
  assign bx_lo = b.x1 < b.x2 ? b.x1 : b.x2;
  assign bx_hi = b.x1 < b.x2 ? b.x2 : b.x1;
  assign by_lo = b.y1 < b.y2 ? b.y1 : b.y2;
  assign by_hi = b.y1 < b.y2 ? b.y2 : b.y1;
  assign hit = ax_lo <= bx_hi && bx_lo <= ax_hi && ay_lo <= by_hi && by_lo <= ay_hi;
endmodule

// File: rtl/hit_resolver.sv
// hit_resolver: detects attack contact, applies damage/stun, tracks health and round outcome (clk, rst, restart, pl boxes in; hp/hit/stun/ko/winner out)
module hit_resolver
  import fight_pkg::*;
#(
  parameter int unsigned HP_MAX = 100,
  parameter int unsigned BASIC_DMG = 10,
  parameter int unsigned DIR_DMG = 15,
  parameter int unsigned CHIP_DMG = 1,
  parameter int unsigned STUN_CYCLES = 12,
  parameter int unsigned KO_CYCLES = 60,
  parameter logic [3:0] DIR_ACTIVE_STATE = DIR_ACTIVE
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  hit_resolver_if.slave pl,
  output logic [6:0] hp_l,
  output logic [6:0] hp_r,
  output logic hit_l,
  output logic hit_r,
  output logic stun_l,
  output logic stun_r,
  output logic ko,
  output logic [1:0] winner
);
  round_t round;
  logic landed_l, landed_r;
  logic [7:0] stun_cnt_l, stun_cnt_r;
  logic [15:0] ko_cnt;
  logic ov_bl, ov_dl, ov_br, ov_dr;
  logic live_bl, live_dl, live_br, live_dr;
  logic dir_hit_l, dir_hit_r, atk_l, atk_r, block_l, block_r;
  logic [6:0] dmg_l, dmg_r, hp_l_n, hp_r_n;
  box_overlap u_bl (.a(pl.basic_l), .b(pl.hurt_r), .hit(ov_bl));
  box_overlap u_dl (.a(pl.dir_l), .b(pl.hurt_r), .hit(ov_dl));
  box_overlap u_br (.a(pl.basic_r), .b(pl.hurt_l), .hit(ov_br));
  box_overlap u_dr (.a(pl.dir_r), .b(pl.hurt_l), .hit(ov_dr));
  assign live_bl = pl.state_l == S_B_ATTACK_END;
  assign live_dl = pl.state_l == DIR_ACTIVE_STATE;
  assign live_br = pl.state_r == S_B_ATTACK_END;
  assign live_dr = pl.state_r == DIR_ACTIVE_STATE;
  assign block_l = pl.state_l == S_MOVEBACKWARDS;
  assign block_r = pl.state_r == S_MOVEBACKWARDS;
  // a live directional contact takes precedence over a simultaneous basic one
  assign dir_hit_l = live_dl && ov_dl;
  assign dir_hit_r = live_dr && ov_dr;
  // atk_l: left lands a hit on right this cycle
  assign atk_l = round == R_FIGHT && !landed_l && (dir_hit_l || (live_bl && ov_bl));
  assign atk_r = round == R_FIGHT && !landed_r && (dir_hit_r || (live_br && ov_br));
  assign dmg_r = block_r ? 7'(CHIP_DMG) : dir_hit_l ? 7'(DIR_DMG) : 7'(BASIC_DMG);
  assign dmg_l = block_l ? 7'(CHIP_DMG) : dir_hit_r ? 7'(DIR_DMG) : 7'(BASIC_DMG);
  assign hp_r_n = atk_l ? sub_sat(hp_r, dmg_r) : hp_r;
  assign hp_l_n = atk_r ? sub_sat(hp_l, dmg_l) : hp_l;
  assign stun_l = stun_cnt_l != 8'd0;
  assign stun_r = stun_cnt_r != 8'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      round <= R_FIGHT;
      hp_l <= 7'(HP_MAX);
      hp_r <= 7'(HP_MAX);
      hit_l <= 1'b0;
      hit_r <= 1'b0;
      landed_l <= 1'b0;
      landed_r <= 1'b0;
      stun_cnt_l <= 8'd0;
      stun_cnt_r <= 8'd0;
      ko_cnt <= 16'd0;
      ko <= 1'b0;
      winner <= W_NONE;
    end else begin
      hit_l <= atk_r;
      hit_r <= atk_l;
      hp_l <= hp_l_n;
      hp_r <= hp_r_n;
      landed_l <= (live_bl || live_dl) && (landed_l || atk_l);
      landed_r <= (live_br || live_dr) && (landed_r || atk_r);
      stun_cnt_l <= atk_r && !block_l ? 8'(STUN_CYCLES) : stun_l ? stun_cnt_l - 8'd1 : 8'd0;
      stun_cnt_r <= atk_l && !block_r ? 8'(STUN_CYCLES) : stun_r ? stun_cnt_r - 8'd1 : 8'd0;
      case (round)
        R_FIGHT: if (hp_l_n == 7'd0 || hp_r_n == 7'd0) begin
          round <= R_KO;
          ko <= 1'b1;
          ko_cnt <= 16'd0;
          winner <= {hp_l_n == 7'd0, hp_r_n == 7'd0};
        end
        R_KO: begin
          ko_cnt <= ko_cnt + 16'd1;
          if (ko_cnt == 16'(KO_CYCLES - 1)) round <= R_OVER;
        end
        R_OVER: if (restart) begin
          round <= R_FIGHT;
          hp_l <= 7'(HP_MAX);
          hp_r <= 7'(HP_MAX);
          hit_l <= 1'b0;
          hit_r <= 1'b0;
          landed_l <= 1'b0;
          landed_r <= 1'b0;
          stun_cnt_l <= 8'd0;
          stun_cnt_r <= 8'd0;
          ko <= 1'b0;
          winner <= W_NONE;
        end
        default: round <= R_FIGHT;
      endcase
    end
  end
endmodule
